// File: rtl/alu_exec_unit.sv
// Execution unit behind the ALU control decoder: single-cycle logic/arith/compare
// ops plus an iterative 32-cycle shift-add unsigned multiply with start/busy/done.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic        zero,
  output logic        ovf
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;

  logic [0:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2*W-1:0] acc, acc_n;
  logic [W-1:0]  mcand, mcand_n;
  logic [W-1:0]  mplier, mplier_n;
  logic          busy_n, done_n, zero_n, ovf_n;
  logic [W-1:0]  result_n, hi_n;

  logic [W-1:0]   sum;
  logic [W:0]     diff33;
  logic [W-1:0]   op_res;
  logic           op_ovf;
  logic [W:0]     add33;
  logic [2*W-1:0] acc_step;

  assign sum    = a + b;
  // Sign-extended difference: bit 32 is the exact sign of a-b even on overflow.
  assign diff33 = {a[W-1], a} - {b[W-1], b};

  // Single-cycle operation result and overflow.
  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (alu_ctl)
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_NOR: op_res = ~(a | b);
      OP_ADD: begin
        op_res = sum;
        op_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        op_res = diff33[W-1:0];
        op_ovf = (a[W-1] != b[W-1]) && (diff33[W-1] != a[W-1]);
      end
      OP_SLT: op_res = W'(diff33[W]);
      default: op_res = '0;
    endcase
  end

  // One shift-add step: conditionally add multiplicand into upper word, shift right.
  assign add33    = {1'b0, acc[2*W-1:W]} + (mplier[cnt] ? {1'b0, mcand} : {(W+1){1'b0}});
  assign acc_step = {add33, acc[W-1:1]};

  // Next-state and output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    hi_n     = hi;
    zero_n   = zero;
    ovf_n    = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          if (alu_ctl == OP_MULTU) begin
            state_n  = MUL;
            busy_n   = 1'b1;
            mcand_n  = a;
            mplier_n = b;
            acc_n    = '0;
            cnt_n    = '0;
          end else begin
            done_n   = 1'b1;
            result_n = op_res;
            hi_n     = '0;
            zero_n   = (op_res == '0);
            ovf_n    = op_ovf;
          end
        end
      end
      MUL: begin
        acc_n = acc_step;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          state_n  = IDLE;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          result_n = acc_step[W-1:0];
          hi_n     = acc_step[2*W-1:W];
          zero_n   = (acc_step[W-1:0] == '0);
          ovf_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
      hi     <= hi_n;
      zero   <= zero_n;
      ovf    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and random ops against a
// plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctl = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, zero, ovf;
  logic [31:0] result, hi;

  int checks = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctl(alu_ctl), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: returns {ovf, hi, result} from the op definitions.
  function automatic logic [64:0] ref_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, t;
    logic [63:0] p;
    logic [31:0] r, h;
    logic o;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 32'd0; h = 32'd0; o = 1'b0; t = 0; p = 64'd0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin t = sx + sy; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0110: begin t = sx - sy; r = t[31:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      4'b1000: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; end
      default: r = 32'd0;
    endcase
    return {o, h, r};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, result, hi, zero, ovf} !== 68'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h hi=%h zero=%b ovf=%b, required all 0",
               busy, done, result, hi, zero, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    logic [3:0]  dc [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0010, 4'b0110};
    logic [31:0] da [6] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd1, 32'h80000000, 32'h80000000};
    logic [31:0] db [6] = '{32'd1, 32'd5, 32'd1, 32'h80000000, 32'h80000000, 32'd1};
    logic [64:0] e;
    for (int i = 0; i < 46; i++) begin
      if (i < 6) begin
        alu_ctl = dc[i]; a = da[i]; b = db[i];
      end else begin
        alu_ctl = 4'($urandom_range(0, 15));
        if (alu_ctl == 4'b1000) alu_ctl = 4'b0110;
        a = $urandom;
        b = (i % 5 == 0) ? a : $urandom;
      end
      e = ref_op(alu_ctl, a, b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_handshake[%0d]: done=%b busy=%b, required done=1 busy=0", i, done, busy);
      end
      checks++;
      if (result !== e[31:0] || hi !== 32'd0) begin
        failures++;
        $display("FAIL single_result[%0d] ctl=%b a=%h b=%h: result=%h hi=%h, required result=%h hi=0",
                 i, alu_ctl, a, b, result, hi, e[31:0]);
      end
      checks++;
      if (zero !== (e[31:0] == 32'd0) || ovf !== e[64]) begin
        failures++;
        $display("FAIL single_flags[%0d] ctl=%b a=%h b=%h: zero=%b ovf=%b, required zero=%b ovf=%b",
                 i, alu_ctl, a, b, zero, ovf, (e[31:0] == 32'd0), e[64]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_drop: done=%b, required 0", done);
    end
  endtask

  // Launches a multiply in the current cycle; returns in its completion cycle.
  task automatic test_multu(input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [64:0] e;
    logic [31:0] prev;
    e = ref_op(4'b1000, x, y);
    alu_ctl = 4'b1000; a = x; b = y; start = 1'b1;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        prev = result;
        a = $urandom; b = $urandom; alu_ctl = 4'b0001;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL mul_busy cyc=%0d: busy=%b done=%b, required busy=1 done=0", cyc, busy, done);
      end
      if (cyc == 20) begin
        checks++;
        if (result !== prev) begin
          failures++;
          $display("FAIL mul_hold: result=%h, required held %h", result, prev);
        end
      end
      if (cyc == 10 && inject) begin
        start = 1'b1; alu_ctl = 4'b0010;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mul_done a=%h b=%h: done=%b busy=%b, required done=1 busy=0", x, y, done, busy);
    end
    checks++;
    if (hi !== e[63:32] || result !== e[31:0]) begin
      failures++;
      $display("FAIL mul_product a=%h b=%h: hi=%h result=%h, required hi=%h result=%h",
               x, y, hi, result, e[63:32], e[31:0]);
    end
    checks++;
    if (zero !== (e[31:0] == 32'd0) || ovf !== 1'b0) begin
      failures++;
      $display("FAIL mul_flags a=%h b=%h: zero=%b ovf=%b, required zero=%b ovf=0",
               x, y, zero, ovf, (e[31:0] == 32'd0));
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    alu_ctl = 4'b1000; a = 32'hDEADBEEF; b = 32'h12345679; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, hi, zero, ovf} !== 68'd0) begin
      failures++;
      $display("FAIL midmul_reset: busy=%b done=%b result=%h hi=%h zero=%b ovf=%b, required all 0",
               busy, done, result, hi, zero, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midmul_abort: done/busy observed=1 after reset, required 0");
    end
    alu_ctl = 4'b0000; a = 32'hF0F0F0F0; b = 32'hFF00FF00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'hF000F000 || zero !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_and: done=%b result=%h zero=%b, required done=1 result=f000f000 zero=0",
               done, result, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c  [3] = '{4'b0001, 4'b1100, 4'b0101};
    logic [31:0] xa [3] = '{32'h0F, 32'h0, 32'h12345678};
    logic [31:0] xb [3] = '{32'hF0, 32'h0, 32'h9ABCDEF0};
    logic [31:0] er [3] = '{32'hFF, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      alu_ctl = c[i]; a = xa[i]; b = xb[i]; start = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== er[i] || zero !== (er[i] == 32'd0) || hi !== 32'd0) begin
        failures++;
        $display("FAIL b2b[%0d]: done=%b result=%h zero=%b hi=%h, required done=1 result=%h zero=%b hi=0",
                 i, done, result, zero, hi, er[i], (er[i] == 32'd0));
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: done=%b, required 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_multu(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    test_multu(32'h00010000, 32'h00010000, 1'b0);
    test_multu(32'h00000000, 32'h12345678, 1'b0);
    for (int i = 0; i < 4; i++) test_multu($urandom, $urandom, 1'b0);
    @(negedge clk);
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
